// File: rtl/pkt_lock_pkg.sv
// Shared types and helpers for the packet-locking mux.
package pkt_lock_pkg;
  localparam int MAX_NUM = 16;
  localparam int MAX_SW  = 4;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } state_t;

  // OR-reduction of set bit positions; exact for a one-hot input
  function automatic logic [MAX_SW-1:0] oh2idx(input logic [MAX_NUM-1:0] oh);
    logic [MAX_SW-1:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_NUM; i++)
      if (oh[i]) idx = idx | MAX_SW'(i);
    return idx;
  endfunction
endpackage

// File: rtl/pkt_lock_mux_if.sv
// Source, arbiter and sink signals of the packet-locking mux.
interface pkt_lock_mux_if #(
  parameter int NUM = 4,
  parameter int DW  = 32,
  parameter int SW  = $clog2(NUM)
) ();
  logic [NUM-1:0]    s_valid_i;
  logic [NUM*DW-1:0] s_data_i;
  logic [NUM-1:0]    s_last_i;
  logic [NUM-1:0]    s_ready_o;
  logic [NUM-1:0]    arb_req_o;
  logic [NUM-1:0]    arb_gnt_i;
  logic              m_valid_o;
  logic [DW-1:0]     m_data_o;
  logic              m_last_o;
  logic [SW-1:0]     m_src_o;
  logic              m_ready_i;
  logic              err_o;

  modport slave (
    input  s_valid_i, s_data_i, s_last_i, arb_gnt_i, m_ready_i,
    output s_ready_o, arb_req_o, m_valid_o, m_data_o, m_last_o, m_src_o, err_o
  );

  modport master (
    output s_valid_i, s_data_i, s_last_i, arb_gnt_i, m_ready_i,
    input  s_ready_o, arb_req_o, m_valid_o, m_data_o, m_last_o, m_src_o, err_o
  );
endinterface

// File: rtl/pkt_out_slice.sv
// Single-entry valid/ready output register; refills in the same cycle it drains.
module pkt_out_slice #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);
  assign in_ready = !out_valid || out_ready;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (in_ready) begin
      out_valid <= in_valid;
      if (in_valid) out_data <= in_data;
    end
  end
endmodule

// File: rtl/pkt_lock_mux.sv
// Packet mux: locks onto one externally granted source until its last beat is accepted.
module pkt_lock_mux
  import pkt_lock_pkg::*;
#(
  parameter int NUM = 4,
  parameter int DW  = 32,
  parameter int SW  = $clog2(NUM)
) (
  input logic         clk_i,
  input logic         rst_i,
  pkt_lock_mux_if.slave bus
);
  localparam int OW = DW + 1 + SW;

  state_t         state, state_nxt;
  logic [NUM-1:0] lock, lock_nxt, cand;
  logic           err, err_nxt;
  logic           out_free, xfer, multi_gnt, m_valid;
  logic [SW-1:0]  idx;
  logic [DW-1:0]  sel_data;
  logic [OW-1:0]  out_word;

  assign idx       = SW'(oh2idx(MAX_NUM'(lock)));
  assign sel_data  = bus.s_data_i[int'(idx)*DW +: DW];
  assign cand      = bus.arb_gnt_i & bus.s_valid_i;
  assign multi_gnt = (bus.arb_gnt_i & (bus.arb_gnt_i - NUM'(1))) != '0;

  assign bus.arb_req_o = (state == IDLE) ? bus.s_valid_i : '0;
  assign bus.s_ready_o = (state == LOCK) ? (lock & {NUM{out_free}}) : '0;
  assign xfer          = |(bus.s_valid_i & bus.s_ready_o);
  assign bus.err_o     = err;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
      lock  <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_nxt;
      lock  <= lock_nxt;
      err   <= err_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    lock_nxt  = lock;
    err_nxt   = err;
    case (state)
      IDLE: begin
        // a one-hot grant that hits a valid port makes cand equal to that grant
        if (multi_gnt) err_nxt = 1'b1;
        else if (cand != '0) begin
          lock_nxt  = cand;
          state_nxt = LOCK;
        end
      end
      LOCK: begin
        if (xfer && bus.s_last_i[idx]) begin
          lock_nxt  = '0;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  pkt_out_slice #(.W(OW)) u_out (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .in_valid  (xfer),
    .in_ready  (out_free),
    .in_data   ({sel_data, bus.s_last_i[idx], idx}),
    .out_valid (m_valid),
    .out_ready (bus.m_ready_i),
    .out_data  (out_word)
  );

  assign bus.m_valid_o = m_valid;
  assign {bus.m_data_o, bus.m_last_o, bus.m_src_o} = out_word;
endmodule

// File: tb/tb_pkt_lock_mux.sv
// Bench for pkt_lock_mux: directed timing scenarios plus a randomized packet scoreboard.
module tb_pkt_lock_mux;
  localparam int NUM = 4, DW = 32, SW = 2;

  logic clk = 1'b0, rst = 1'b0;
  int n_run = 0, n_fail = 0;
  bit force_en = 1'b0;
  logic [NUM-1:0] force_gnt = '0;

  logic [31:0] bq_d[NUM][$];
  bit          bq_l[NUM][$];
  logic [31:0] ex_d[NUM][$];
  bit          ex_l[NUM][$];
  logic [31:0] got_d[$];
  bit          got_l[$];
  int          got_s[$];

  pkt_lock_mux_if #(.NUM(NUM), .DW(DW), .SW(SW)) bus ();
  pkt_lock_mux #(.NUM(NUM), .DW(DW), .SW(SW)) dut (.clk_i(clk), .rst_i(rst), .bus(bus.slave));

  always #5 clk = ~clk;

  // external fixed-priority arbiter: lowest index wins, unless a grant is forced
  always_comb bus.arb_gnt_i = force_en ? force_gnt : (bus.arb_req_o & (~bus.arb_req_o + NUM'(1)));

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic tick(); @(posedge clk); #1; endtask
  task automatic smp();  @(negedge clk);     endtask

  task automatic set_port(input int p, input logic v, input logic [31:0] d, input logic l);
    bus.s_valid_i[p] = v;
    bus.s_data_i[p*DW +: DW] = d;
    bus.s_last_i[p] = l;
  endtask

  task automatic idle_inputs();
    bus.s_valid_i = '0; bus.s_data_i = '0; bus.s_last_i = '0;
    bus.m_ready_i = 1'b1; force_en = 1'b0; force_gnt = '0;
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1; idle_inputs();
    @(negedge clk); rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; idle_inputs(); bus.s_valid_i = 4'b0101; #2;
    n_run++; if (bus.m_valid_o !== 1'b0) begin n_fail++; $display("FAIL rst_m_valid got=%0b exp=0", bus.m_valid_o); end
    n_run++; if (bus.m_data_o !== 32'h0) begin n_fail++; $display("FAIL rst_m_data got=%0h exp=0", bus.m_data_o); end
    n_run++; if (bus.m_last_o !== 1'b0) begin n_fail++; $display("FAIL rst_m_last got=%0b exp=0", bus.m_last_o); end
    n_run++; if (bus.m_src_o !== 2'd0) begin n_fail++; $display("FAIL rst_m_src got=%0d exp=0", bus.m_src_o); end
    n_run++; if (bus.err_o !== 1'b0) begin n_fail++; $display("FAIL rst_err got=%0b exp=0", bus.err_o); end
    n_run++; if (bus.s_ready_o !== 4'b0000) begin n_fail++; $display("FAIL rst_s_ready got=%b exp=0000", bus.s_ready_o); end
    n_run++; if (bus.arb_req_o !== 4'b0101) begin n_fail++; $display("FAIL rst_arb_req got=%b exp=0101", bus.arb_req_o); end
    @(negedge clk); rst = 1'b0; bus.s_valid_i = '0;
    tick();
  endtask

  task automatic test_three_beat();
    logic [31:0] d0, d1, d2;
    d0 = $urandom; d1 = $urandom; d2 = $urandom;
    set_port(2, 1, d0, 0); smp();
    n_run++; if (bus.arb_req_o !== 4'b0100) begin n_fail++; $display("FAIL tb3_req got=%b exp=0100", bus.arb_req_o); end
    n_run++; if (bus.s_ready_o !== 4'b0000) begin n_fail++; $display("FAIL tb3_grant_cycle_ready got=%b exp=0000", bus.s_ready_o); end
    tick(); smp();
    n_run++; if (bus.s_ready_o !== 4'b0100 || bus.arb_req_o !== 4'b0000) begin n_fail++; $display("FAIL tb3_lock got rdy=%b req=%b exp rdy=0100 req=0000", bus.s_ready_o, bus.arb_req_o); end
    n_run++; if (bus.m_valid_o !== 1'b0) begin n_fail++; $display("FAIL tb3_early_valid got=%0b exp=0", bus.m_valid_o); end
    tick(); set_port(2, 1, d1, 0); smp();
    n_run++; if (bus.m_valid_o !== 1'b1 || bus.m_data_o !== d0 || bus.m_src_o !== 2'd2 || bus.m_last_o !== 1'b0) begin n_fail++; $display("FAIL tb3_beat0 got v=%0b d=%h s=%0d l=%0b exp v=1 d=%h s=2 l=0", bus.m_valid_o, bus.m_data_o, bus.m_src_o, bus.m_last_o, d0); end
    tick(); set_port(2, 1, d2, 1); smp();
    n_run++; if (bus.m_valid_o !== 1'b1 || bus.m_data_o !== d1 || bus.m_last_o !== 1'b0) begin n_fail++; $display("FAIL tb3_beat1 got v=%0b d=%h l=%0b exp v=1 d=%h l=0", bus.m_valid_o, bus.m_data_o, bus.m_last_o, d1); end
    tick(); set_port(2, 0, 0, 0); smp();
    n_run++; if (bus.m_valid_o !== 1'b1 || bus.m_data_o !== d2 || bus.m_last_o !== 1'b1 || bus.m_src_o !== 2'd2) begin n_fail++; $display("FAIL tb3_beat2 got v=%0b d=%h s=%0d l=%0b exp v=1 d=%h s=2 l=1", bus.m_valid_o, bus.m_data_o, bus.m_src_o, bus.m_last_o, d2); end
    n_run++; if (bus.s_ready_o !== 4'b0000) begin n_fail++; $display("FAIL tb3_unlock got=%b exp=0000", bus.s_ready_o); end
    tick(); smp();
    n_run++; if (bus.m_valid_o !== 1'b0) begin n_fail++; $display("FAIL tb3_drain got=%0b exp=0", bus.m_valid_o); end
    tick();
  endtask

  task automatic test_lock_hold();
    logic [31:0] a0, a1, a2, b0;
    a0 = $urandom; a1 = $urandom; a2 = $urandom; b0 = $urandom;
    set_port(1, 1, a0, 0); smp();
    n_run++; if (bus.arb_req_o !== 4'b0010) begin n_fail++; $display("FAIL hold_req got=%b exp=0010", bus.arb_req_o); end
    tick(); set_port(0, 1, b0, 1); smp();
    n_run++; if (bus.s_ready_o !== 4'b0010) begin n_fail++; $display("FAIL hold_rdy0 got=%b exp=0010", bus.s_ready_o); end
    tick(); set_port(1, 1, a1, 0); smp();
    n_run++; if (bus.s_ready_o !== 4'b0010 || bus.arb_req_o !== 4'b0000) begin n_fail++; $display("FAIL hold_rdy1 got rdy=%b req=%b exp rdy=0010 req=0000", bus.s_ready_o, bus.arb_req_o); end
    tick(); set_port(1, 1, a2, 1); smp();
    n_run++; if (bus.s_ready_o !== 4'b0010) begin n_fail++; $display("FAIL hold_rdy2 got=%b exp=0010", bus.s_ready_o); end
    tick(); set_port(1, 0, 0, 0); smp();
    n_run++; if (bus.arb_req_o !== 4'b0001 || bus.s_ready_o !== 4'b0000) begin n_fail++; $display("FAIL hold_rearb got req=%b rdy=%b exp req=0001 rdy=0000", bus.arb_req_o, bus.s_ready_o); end
    n_run++; if (bus.m_data_o !== a2 || bus.m_last_o !== 1'b1 || bus.m_src_o !== 2'd1) begin n_fail++; $display("FAIL hold_last got d=%h l=%0b s=%0d exp d=%h l=1 s=1", bus.m_data_o, bus.m_last_o, bus.m_src_o, a2); end
    tick(); smp();
    n_run++; if (bus.s_ready_o !== 4'b0001) begin n_fail++; $display("FAIL hold_p0_rdy got=%b exp=0001", bus.s_ready_o); end
    tick(); set_port(0, 0, 0, 0); smp();
    n_run++; if (bus.m_valid_o !== 1'b1 || bus.m_src_o !== 2'd0 || bus.m_data_o !== b0 || bus.m_last_o !== 1'b1) begin n_fail++; $display("FAIL hold_p0_beat got v=%0b s=%0d d=%h l=%0b exp v=1 s=0 d=%h l=1", bus.m_valid_o, bus.m_src_o, bus.m_data_o, bus.m_last_o, b0); end
    tick();
  endtask

  task automatic test_backpressure();
    logic [31:0] d0, d1, d2;
    d0 = $urandom; d1 = $urandom; d2 = $urandom;
    set_port(3, 1, d0, 0); smp(); tick(); smp(); tick();
    set_port(3, 1, d1, 0); bus.m_ready_i = 1'b0;
    for (int c = 0; c < 3; c++) begin
      smp();
      n_run++; if (bus.m_valid_o !== 1'b1 || bus.m_data_o !== d0 || bus.s_ready_o !== 4'b0000) begin n_fail++; $display("FAIL bp_stall%0d got v=%0b d=%h rdy=%b exp v=1 d=%h rdy=0000", c, bus.m_valid_o, bus.m_data_o, bus.s_ready_o, d0); end
      tick();
    end
    bus.m_ready_i = 1'b1; smp();
    n_run++; if (bus.s_ready_o !== 4'b1000 || bus.m_data_o !== d0) begin n_fail++; $display("FAIL bp_resume got rdy=%b d=%h exp rdy=1000 d=%h", bus.s_ready_o, bus.m_data_o, d0); end
    tick(); set_port(3, 1, d2, 1); smp();
    n_run++; if (bus.m_valid_o !== 1'b1 || bus.m_data_o !== d1 || bus.m_last_o !== 1'b0) begin n_fail++; $display("FAIL bp_beat1 got v=%0b d=%h l=%0b exp v=1 d=%h l=0", bus.m_valid_o, bus.m_data_o, bus.m_last_o, d1); end
    tick(); set_port(3, 0, 0, 0); smp();
    n_run++; if (bus.m_valid_o !== 1'b1 || bus.m_data_o !== d2 || bus.m_last_o !== 1'b1) begin n_fail++; $display("FAIL bp_beat2 got v=%0b d=%h l=%0b exp v=1 d=%h l=1", bus.m_valid_o, bus.m_data_o, bus.m_last_o, d2); end
    tick(); smp();
    n_run++; if (bus.m_valid_o !== 1'b0) begin n_fail++; $display("FAIL bp_drain got=%0b exp=0", bus.m_valid_o); end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [31:0] a, b;
    a = $urandom; b = $urandom;
    set_port(3, 1, a, 1); set_port(0, 1, b, 1); force_en = 1'b1; force_gnt = 4'b1000; smp();
    n_run++; if (bus.arb_req_o !== 4'b1001) begin n_fail++; $display("FAIL b2b_req got=%b exp=1001", bus.arb_req_o); end
    tick(); force_en = 1'b0; smp();
    n_run++; if (bus.s_ready_o !== 4'b1000) begin n_fail++; $display("FAIL b2b_rdy3 got=%b exp=1000", bus.s_ready_o); end
    tick(); set_port(3, 0, 0, 0); smp();
    n_run++; if (bus.m_valid_o !== 1'b1 || bus.m_src_o !== 2'd3 || bus.m_data_o !== a) begin n_fail++; $display("FAIL b2b_first got v=%0b s=%0d d=%h exp v=1 s=3 d=%h", bus.m_valid_o, bus.m_src_o, bus.m_data_o, a); end
    tick(); smp();
    n_run++; if (bus.m_valid_o !== 1'b0 || bus.s_ready_o !== 4'b0001) begin n_fail++; $display("FAIL b2b_gap got v=%0b rdy=%b exp v=0 rdy=0001", bus.m_valid_o, bus.s_ready_o); end
    tick(); set_port(0, 0, 0, 0); smp();
    n_run++; if (bus.m_valid_o !== 1'b1 || bus.m_src_o !== 2'd0 || bus.m_data_o !== b || bus.m_last_o !== 1'b1) begin n_fail++; $display("FAIL b2b_second got v=%0b s=%0d d=%h l=%0b exp v=1 s=0 d=%h l=1", bus.m_valid_o, bus.m_src_o, bus.m_data_o, bus.m_last_o, b); end
    tick();
  endtask

  task automatic test_nonvalid_grant();
    set_port(0, 1, $urandom, 1); force_en = 1'b1; force_gnt = 4'b0100; smp();
    tick(); smp();
    n_run++; if (bus.arb_req_o !== 4'b0001 || bus.s_ready_o !== 4'b0000 || bus.err_o !== 1'b0) begin n_fail++; $display("FAIL nvg_idle got req=%b rdy=%b err=%0b exp req=0001 rdy=0000 err=0", bus.arb_req_o, bus.s_ready_o, bus.err_o); end
    tick(); set_port(0, 0, 0, 0); force_en = 1'b0; tick();
  endtask

  task automatic test_bad_grant();
    set_port(0, 1, $urandom, 0); set_port(1, 1, $urandom, 0); force_en = 1'b1; force_gnt = 4'b0011; smp();
    n_run++; if (bus.err_o !== 1'b0) begin n_fail++; $display("FAIL bad_err_early got=%0b exp=0", bus.err_o); end
    tick(); smp();
    n_run++; if (bus.err_o !== 1'b1 || bus.arb_req_o !== 4'b0011 || bus.s_ready_o !== 4'b0000) begin n_fail++; $display("FAIL bad_grant got err=%0b req=%b rdy=%b exp err=1 req=0011 rdy=0000", bus.err_o, bus.arb_req_o, bus.s_ready_o); end
    tick(); set_port(0, 0, 0, 0); set_port(1, 0, 0, 0); force_en = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick(); smp();
      n_run++; if (bus.err_o !== 1'b1) begin n_fail++; $display("FAIL bad_sticky%0d got=%0b exp=1", c, bus.err_o); end
    end
    tick();
  endtask

  task automatic test_mid_reset();
    logic [31:0] d0, d1;
    d0 = $urandom; d1 = $urandom;
    set_port(2, 1, d0, 0); smp(); tick(); smp(); tick();
    set_port(2, 1, d1, 0);
    #2 rst = 1'b1; #1;
    n_run++; if (bus.m_valid_o !== 1'b0 || bus.s_ready_o !== 4'b0000 || bus.err_o !== 1'b0 || bus.m_data_o !== 32'h0) begin n_fail++; $display("FAIL mrst_async got v=%0b rdy=%b err=%0b d=%h exp v=0 rdy=0000 err=0 d=0", bus.m_valid_o, bus.s_ready_o, bus.err_o, bus.m_data_o); end
    @(negedge clk); rst = 1'b0; force_en = 1'b1; force_gnt = '0;
    tick();
    for (int c = 0; c < 2; c++) begin
      smp();
      n_run++; if (bus.m_valid_o !== 1'b0 || bus.s_ready_o !== 4'b0000 || bus.arb_req_o !== 4'b0100) begin n_fail++; $display("FAIL mrst_nogrant%0d got v=%0b rdy=%b req=%b exp v=0 rdy=0000 req=0100", c, bus.m_valid_o, bus.s_ready_o, bus.arb_req_o); end
      tick();
    end
    force_en = 1'b0; smp();
    n_run++; if (bus.m_valid_o !== 1'b0 || bus.s_ready_o !== 4'b0000) begin n_fail++; $display("FAIL mrst_grant got v=%0b rdy=%b exp v=0 rdy=0000", bus.m_valid_o, bus.s_ready_o); end
    tick(); smp();
    n_run++; if (bus.s_ready_o !== 4'b0100 || bus.m_valid_o !== 1'b0) begin n_fail++; $display("FAIL mrst_lock got rdy=%b v=%0b exp rdy=0100 v=0", bus.s_ready_o, bus.m_valid_o); end
    tick(); set_port(2, 0, 0, 0); smp();
    n_run++; if (bus.m_valid_o !== 1'b1 || bus.m_data_o !== d1 || bus.m_src_o !== 2'd2) begin n_fail++; $display("FAIL mrst_first got v=%0b d=%h s=%0d exp v=1 d=%h s=2", bus.m_valid_o, bus.m_data_o, bus.m_src_o, d1); end
    tick();
  endtask

  task automatic rnd_cycle();
    @(negedge clk);
    if (bus.m_valid_o && bus.m_ready_i) begin
      got_d.push_back(bus.m_data_o); got_l.push_back(bus.m_last_o); got_s.push_back(int'(bus.m_src_o));
    end
    for (int p = 0; p < NUM; p++)
      if (bus.s_valid_i[p] && bus.s_ready_o[p]) begin
        bq_d[p].delete(0); bq_l[p].delete(0);
      end
    tick();
    for (int p = 0; p < NUM; p++)
      if (bq_d[p].size() != 0 && $urandom_range(3) != 0) set_port(p, 1, bq_d[p][0], bq_l[p][0]);
      else set_port(p, 0, $urandom, 0);
    bus.m_ready_i = ($urandom_range(3) != 0);
  endtask

  task automatic test_random();
    int total, cyc, cur, s, pend;
    logic [31:0] ed;
    bit el;
    do_reset();
    total = 0;
    for (int p = 0; p < NUM; p++)
      for (int k = 0; k < 3; k++) begin
        int len;
        len = $urandom_range(1, 4);
        for (int b = 0; b < len; b++) begin
          ed = $urandom; el = (b == len - 1);
          bq_d[p].push_back(ed); bq_l[p].push_back(el);
          ex_d[p].push_back(ed); ex_l[p].push_back(el);
          total++;
        end
      end
    cyc = 0;
    pend = total;
    while ((pend != 0 || bus.m_valid_o) && cyc < 3000) begin
      rnd_cycle();
      cyc++;
      pend = 0;
      for (int p = 0; p < NUM; p++) pend += bq_d[p].size();
    end
    idle_inputs();
    n_run++; if (cyc >= 3000) begin n_fail++; $display("FAIL rnd_timeout cycles=%0d pending=%0d exp drained", cyc, pend); end
    n_run++; if (got_d.size() != total) begin n_fail++; $display("FAIL rnd_count got=%0d exp=%0d", got_d.size(), total); end
    // output must be whole packets, each matching the next unsent packet of its source
    cur = -1;
    for (int i = 0; i < got_d.size(); i++) begin
      s = got_s[i];
      if (cur < 0) cur = s;
      n_run++; if (s != cur) begin n_fail++; $display("FAIL rnd_interleave beat=%0d got src=%0d exp src=%0d", i, s, cur); end
      n_run++;
      if (ex_d[s].size() == 0) begin n_fail++; $display("FAIL rnd_extra beat=%0d src=%0d got d=%h exp none", i, s, got_d[i]); end
      else begin
        ed = ex_d[s].pop_front(); el = ex_l[s].pop_front();
        if (got_d[i] !== ed || got_l[i] !== el) begin n_fail++; $display("FAIL rnd_beat %0d src=%0d got d=%h l=%0b exp d=%h l=%0b", i, s, got_d[i], got_l[i], ed, el); end
      end
      if (got_l[i]) cur = -1;
    end
    for (int p = 0; p < NUM; p++) begin
      n_run++; if (ex_d[p].size() != 0) begin n_fail++; $display("FAIL rnd_missing port=%0d got=%0d left exp=0", p, ex_d[p].size()); end
    end
    tick();
  endtask

  initial begin
    idle_inputs();
    tick();
    test_reset();
    test_three_beat();
    test_lock_hold();
    test_backpressure();
    test_back_to_back();
    test_nonvalid_grant();
    test_bad_grant();
    test_mid_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/pkt_lock_mux.md
PKT_LOCK_MUX -- requirements
Module: pkt_lock_mux

Interface
REQ-001 SHALL have parameter NUM, default 4: number of source ports (2..16).
REQ-002 SHALL have parameter DW, default 32: data width per port.
REQ-003 SHALL have parameter SW, default $clog2(NUM): width of source index.
REQ-004 SHALL have ports:
- clk_i  in  1  clock, all logic on rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- s_valid_i  in  NUM  per-port beat valid.
- s_data_i  in  NUM*DW  per-port data; port k at bits [k*DW +: DW].
- s_last_i  in  NUM  per-port last-beat-of-packet flag.
- s_ready_o  out  NUM  per-port beat accept.
- arb_req_o  out  NUM  request vector to the external priority arbiter.
- arb_gnt_i  in  NUM  one-hot grant from the external priority arbiter (combinational response to arb_req_o).
- m_valid_o  out  1  output beat valid.
- m_data_o  out  DW  output data.
- m_last_o  out  1  output last flag.
- m_src_o  out  SW  index of the source that produced the output beat.
- m_ready_i  in  1  downstream accept.
- err_o  out  1  sticky flag: malformed grant seen.
REQ-005 SHALL use one clock, clk_i; rst_i SHALL be asynchronous and active-high.

Function
REQ-006 SHALL implement FSM states IDLE and LOCK; reset state IDLE.
REQ-007 In IDLE: arb_req_o = s_valid_i; in LOCK: arb_req_o = 0.
REQ-008 In IDLE, when arb_gnt_i & s_valid_i is one-hot, SHALL latch it into lock register and enter LOCK next cycle; no beat is accepted in the grant cycle (one-cycle grant latency).
REQ-009 In IDLE, arb_gnt_i with more than one bit set SHALL be ignored (stay IDLE) and SHALL set err_o; a grant to a non-valid port SHALL be ignored without error.
REQ-010 s_ready_o = lock & {NUM{out_free}}, out_free = !m_valid_o | m_ready_i; s_ready_o = 0 in IDLE.
REQ-011 Beat transfer: locked port k with s_valid_i[k] & s_ready_o[k] SHALL load s_data_i slice, s_last_i[k], and index k into the output register next cycle.
REQ-012 Output register SHALL sustain one beat per cycle while m_ready_i=1; m_valid_o SHALL hold, with data/last/src stable, until m_ready_i=1.
REQ-013 Accepted beat with s_last_i[k]=1 SHALL clear lock and return to IDLE next cycle; re-arbitration SHALL be allowed while the last beat still sits in the output register.
REQ-014 Non-locked ports SHALL never see s_ready_o=1; a packet SHALL never interleave with another.
REQ-015 Single-beat packets (valid and last together) SHALL cost 2 cycles per packet at minimum (grant + transfer).
REQ-016 Lock SHALL persist regardless of higher-priority requests arriving mid-packet.
REQ-017 err_o SHALL stay set until reset.

Reset
REQ-018 On rst_i: state IDLE, lock=0, m_valid_o=0, m_data_o=0, m_last_o=0, m_src_o=0, err_o=0, immediately (asynchronous).
REQ-019 Reset mid-packet SHALL drop the partial packet; no beat presented after reset release until a new grant.

Structure
REQ-020 Shared package pkt_lock_pkg SHALL hold the state enum (IDLE, LOCK) and a onehot-to-index function.
REQ-021 Output register SHALL be one sub-module, pkt_out_slice (valid/ready register of DW+1+SW bits).
REQ-022 Arbiter SHALL stay external; pkt_lock_mux SHALL contain no priority logic.

Verification
REQ-023 NUM=4; port 2 sends 3-beat packet (D0..D2, last on D2), gnt=0100, m_ready=1 -> m_data D0,D1,D2 on consecutive cycles, m_src=2, m_last only on D2.
REQ-024 Port 1 mid-packet, port 0 raises valid -> port 0 s_ready=0 until port 1 last accepted; then gnt=0001 and port 0 packet follows.
REQ-025 m_ready_i held 0 for 3 cycles mid-packet -> m_valid/m_data stable, s_ready=0, no beat lost or duplicated.
REQ-026 IDLE with arb_gnt_i=0011 and valid=0011 -> state stays IDLE, err_o=1 next cycle and stays 1.
REQ-027 rst_i asserted mid-packet (between clock edges) -> m_valid_o=0 and s_ready_o=0 immediately; after release, first beat appears only after a new grant.
REQ-028 Back-to-back single-beat packets on ports 3 and 0 -> output beats spaced 2 cycles, m_src 3 then 0.
